wb_checkpoint_checker: RTL
==========================

# wb_checkpoint_checker

Synthesizable, table-driven self-check engine that watches the CPU's register writeback bus and a debug read port on data memory. When the program writes checkpoint number N into the flag register, it walks all table entries tagged with stage N, compares masked register or memory contents against expected values, and accumulates pass/fail results. It sits beside `Riscv151` in simulation and on FPGA, replacing hand-written per-test check tasks with a loadable, parametrised checker that also adds a per-stage timeout.

## Interface
- XLEN, 32, data width of registers, memory words, masks
- NUM_CHECKS, 16, table depth (entries)
- NUM_STAGES, 8, last checkpoint number; stages run 1..NUM_STAGES
- FLAG_REG, 20, architectural register used as the checkpoint flag
- MEM_AW, 14, dmem word-address width
- TIMEOUT_CYCLES, 100000, max cycles spent in WAIT_FLAG per stage
- clk  in  1  the single clock
- rst  in  1  asynchronous, active-low reset
- tbl_we  in  1  write one table entry (ignored unless IDLE)
- tbl_addr  in  clog2(NUM_CHECKS)  entry index
- tbl_stage  in  8  stage this entry belongs to
- tbl_kind  in  1  0 = register check, 1 = memory check
- tbl_index  in  MEM_AW  reg number (low 5 bits) or dmem word address
- tbl_expect, tbl_mask  in  XLEN  expected value, compare mask
- start  in  1  begin run (IDLE only)
- wb_valid, wb_rd[4:0], wb_data[XLEN]  in  CPU register writeback
- mem_req_valid  out  1, mem_req_ready  in  1, mem_req_addr  out  MEM_AW  dmem debug read request
- mem_rsp_valid  in  1, mem_rsp_data  in  XLEN  read response
- busy, done, timeout  out  1  run status
- pass_count, fail_count  out  16  saturating counters
- fail_pulse  out  1  one-cycle strobe per failing entry, with fail_entry (entry index) and fail_got (XLEN, masked observed value)

## Operation
- Shadow regfile: every cycle with wb_valid and wb_rd != 0, shadow[wb_rd] <= wb_data; x0 reads 0. Updates continue in all states.
- States: IDLE, WAIT_FLAG, SCAN, MEM_REQ, MEM_WAIT, DONE.
- IDLE: table writable. start -> WAIT_FLAG, cur_stage = 1, counters and timeout cleared, done = 0.
- WAIT_FLAG: wb_valid && wb_rd == FLAG_REG && wb_data == cur_stage -> SCAN with ptr = 0, timer cleared. Other flag values ignored. Timer reaches TIMEOUT_CYCLES -> DONE with timeout = 1.
- SCAN: one entry per cycle. If entry is invalid or its stage != cur_stage, ptr++. A REG entry compares (shadow[idx] & mask) vs (expect & mask) in the same cycle, then ptr++. A MEM entry goes to MEM_REQ.
- MEM_REQ: mem_req_valid held with a stable address until mem_req_ready, then MEM_WAIT.
- MEM_WAIT: on mem_rsp_valid, compare masked, return to SCAN with ptr++.
- After the entry at ptr == NUM_CHECKS-1: if cur_stage == NUM_STAGES -> DONE, else cur_stage++ and -> WAIT_FLAG.
- DONE: done = 1; start -> WAIT_FLAG (new run, table retained).
- Compare result: pass -> pass_count++; fail -> fail_count++ and fail_pulse. Both counters saturate at 16'hFFFF.

## Timing
- Reset values: every output 0, state IDLE, all table valid bits 0, shadow all 0.
- Flag detect to first compare: 1 cycle. REG entry: 1 cycle. MEM entry: 1 cycle + ready wait + response latency + 1 cycle.
- A compare and a shadow write to the same register in one cycle: the compare uses the pre-write value.
- The flag write is itself captured in the shadow, so a FLAG_REG entry in the same stage sees cur_stage.
- tbl_we or start outside the legal state is ignored. busy = state not IDLE/DONE.
- Reset mid-run (including mid mem handshake) aborts immediately. mem_req_valid drops asynchronously and a late rsp is ignored.

## Structure
- checker_pkg holds: state enum, check_kind_e, the entry struct {valid, stage, kind, index, expect, mask}, and the counter width constant.
- Sub-module checker_shadow_regfile: 32 x XLEN, one write port, one combinational read port.
- The table is a flop array, so the engine can read it without latency.

## Test plan
- Stage 1 with REG entry x10 expect 32'h0000_00ff, mask 32'hffff_ffff. Bench writes x10 = ff, then x20 = 1 -> pass_count = 1, no fail_pulse.
- MEM entry addr 1, expect 32'h1122_3344, mask 32'h0000_ffff. Response 32'h9999_3344 with 3-cycle ready stall -> pass. Response 32'h9999_3345 -> fail_pulse, fail_got = 32'h0000_3345.
- Flag written as 2 while cur_stage = 1 -> no scan. After TIMEOUT_CYCLES = 50 -> done = 1, timeout = 1.
- Eight stages with two entries each, all matching -> done after stage 8, pass_count = 16, fail_count = 0.
- Writeback to x10 in the same cycle as its compare -> result uses the old value. A wb_rd = 0 write leaves x0 reading 0.
- rst asserted during MEM_WAIT -> all outputs 0 and state IDLE. tbl_we while busy leaves the table unchanged.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared types for the checkpoint checker: FSM states, check kinds and the
// table entry layout used by the engine.
package checker_pkg;

   localparam int ENTRY_XLEN = 32;
   localparam int ENTRY_AW   = 14;
   localparam int CNT_W      = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FLAG,
      S_SCAN,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_DONE
   } state_e;

   typedef enum logic {
      KIND_REG = 1'b0,
      KIND_MEM = 1'b1
   } check_kind_e;

   typedef struct packed {
      logic                  valid;
      logic [7:0]            stage;
      check_kind_e           kind;
      logic [ENTRY_AW-1:0]   index;
      logic [ENTRY_XLEN-1:0] expected;
      logic [ENTRY_XLEN-1:0] mask;
   } entry_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == '1) ? value : value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/checker_shadow_regfile.sv
// Copy of the CPU register file rebuilt from the writeback bus; x0 always
// reads as zero and the read port is combinational.
module checker_shadow_regfile #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] regs [32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (we && waddr != 5'd0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata = (raddr == 5'd0) ? '0 : regs[raddr];

endmodule

// File: rtl/wb_checkpoint_checker.sv
// Table-driven self-check engine: waits for checkpoint N on the flag register,
// then compares every stage-N table entry against shadow registers or dmem.
module wb_checkpoint_checker
   import checker_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NUM_CHECKS     = 16,
   parameter int NUM_STAGES     = 8,
   parameter int FLAG_REG       = 20,
   parameter int MEM_AW         = 14,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tbl_we,
   input  logic [$clog2(NUM_CHECKS)-1:0] tbl_addr,
   input  logic [7:0]                    tbl_stage,
   input  logic                          tbl_kind,
   input  logic [MEM_AW-1:0]             tbl_index,
   input  logic [XLEN-1:0]               tbl_expect,
   input  logic [XLEN-1:0]               tbl_mask,
   input  logic                          start,
   input  logic                          wb_valid,
   input  logic [4:0]                    wb_rd,
   input  logic [XLEN-1:0]               wb_data,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic [MEM_AW-1:0]             mem_req_addr,
   input  logic                          mem_rsp_valid,
   input  logic [XLEN-1:0]               mem_rsp_data,
   output logic                          busy,
   output logic                          done,
   output logic                          timeout,
   output logic [CNT_W-1:0]              pass_count,
   output logic [CNT_W-1:0]              fail_count,
   output logic                          fail_pulse,
   output logic [$clog2(NUM_CHECKS)-1:0] fail_entry,
   output logic [XLEN-1:0]               fail_got
);

   localparam int PTR_W = $clog2(NUM_CHECKS);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e           state;
   entry_t           tbl [NUM_CHECKS];
   entry_t           new_entry;
   entry_t           cur;
   logic [PTR_W-1:0] ptr;
   logic [7:0]       cur_stage;
   logic [TMR_W-1:0] timer;
   logic [XLEN-1:0]  shadow_rdata;
   logic             entry_hit;
   logic             mem_hit;
   logic             flag_hit;
   logic             step;
   logic             last_entry;
   logic             last_stage;
   logic             cmp_fire;
   logic             cmp_pass;
   logic [XLEN-1:0]  cmp_got;

   checker_shadow_regfile #(.XLEN(XLEN)) u_shadow (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_valid),
      .waddr (wb_rd),
      .wdata (wb_data),
      .raddr (cur.index[4:0]),
      .rdata (shadow_rdata)
   );

   always_comb begin
      new_entry          = '0;
      new_entry.valid    = 1'b1;
      new_entry.stage    = tbl_stage;
      new_entry.kind     = check_kind_e'(tbl_kind);
      new_entry.index    = tbl_index;
      new_entry.expected = tbl_expect;
      new_entry.mask     = tbl_mask;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CHECKS; i++) begin
            tbl[i] <= '0;
         end
      end else if (tbl_we && state == S_IDLE) begin
         tbl[tbl_addr] <= new_entry;
      end
   end

   assign cur        = tbl[ptr];
   assign entry_hit  = cur.valid && (cur.stage == cur_stage);
   assign mem_hit    = entry_hit && (cur.kind == KIND_MEM);
   assign flag_hit   = wb_valid && (wb_rd == 5'(FLAG_REG)) && (wb_data == XLEN'(cur_stage));
   assign last_entry = (ptr == PTR_W'(NUM_CHECKS - 1));
   assign last_stage = (cur_stage == 8'(NUM_STAGES));
   assign step       = (state == S_SCAN && !mem_hit) || (state == S_MEM_WAIT && mem_rsp_valid);

   // The shadow read is pre-write, so a same-cycle writeback never leaks into a compare.
   always_comb begin
      cmp_fire = 1'b0;
      cmp_got  = '0;
      if (state == S_SCAN && entry_hit && cur.kind == KIND_REG) begin
         cmp_fire = 1'b1;
         cmp_got  = shadow_rdata & cur.mask;
      end else if (state == S_MEM_WAIT && mem_rsp_valid) begin
         cmp_fire = 1'b1;
         cmp_got  = mem_rsp_data & cur.mask;
      end
      cmp_pass = (cmp_got == (cur.expected & cur.mask));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         ptr           <= '0;
         cur_stage     <= '0;
         timer         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         timeout       <= 1'b0;
         pass_count    <= '0;
         fail_count    <= '0;
         fail_pulse    <= 1'b0;
         fail_entry    <= '0;
         fail_got      <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
      end else begin
         fail_pulse <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state      <= S_WAIT_FLAG;
                  cur_stage  <= 8'd1;
                  ptr        <= '0;
                  timer      <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  timeout    <= 1'b0;
                  pass_count <= '0;
                  fail_count <= '0;
               end
            end
            S_WAIT_FLAG: begin
               if (flag_hit) begin
                  state <= S_SCAN;
                  ptr   <= '0;
                  timer <= '0;
               end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  state   <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_SCAN: begin
               if (mem_hit) begin
                  state         <= S_MEM_REQ;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= cur.index;
               end
            end
            S_MEM_REQ: begin
               if (mem_req_ready) begin
                  state         <= S_MEM_WAIT;
                  mem_req_valid <= 1'b0;
               end
            end
            default: ;
         endcase

         // Advancing past the final table slot closes the current stage.
         if (step) begin
            if (!last_entry) begin
               ptr   <= ptr + PTR_W'(1);
               state <= S_SCAN;
            end else if (last_stage) begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               cur_stage <= cur_stage + 8'd1;
               timer     <= '0;
               state     <= S_WAIT_FLAG;
            end
         end

         if (cmp_fire) begin
            if (cmp_pass) begin
               pass_count <= sat_inc(pass_count);
            end else begin
               fail_count <= sat_inc(fail_count);
               fail_pulse <= 1'b1;
               fail_entry <= ptr;
               fail_got   <= cmp_got;
            end
         end
      end
   end

endmodule
